konata_trace_buffer: RTL

KONATA_TRACE_BUFFER -- requirements
Module: konata_trace_buffer

---
 rtl/konata_trace_buffer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/konata_trace_buffer.sv
// rtl/konata_trace_buffer.sv - pipeline trace recorder with trigger FSM, on-change filter and record FIFO
// Records {gap, timestamp, valid/stall/flush masks, ids} into a FIFO; drops are counted and flagged.
module konata_trace_buffer #(
  parameter int NUM_STAGES = 6,
  parameter int ID_W       = 64,
  parameter int TS_W       = 32,
  parameter int DEPTH      = 16,
  parameter int ON_CHANGE  = 1,
  localparam int REC_W     = 1 + TS_W + 3*NUM_STAGES + NUM_STAGES*ID_W,
  localparam int AW        = $clog2(DEPTH),
  localparam int OCC_W     = AW + 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       trace_en,
  input  logic                       trig,
  input  logic                       use_trig,
  input  logic [NUM_STAGES-1:0]      stage_valid,
  input  logic [NUM_STAGES-1:0]      stage_stall,
  input  logic [NUM_STAGES-1:0]      stage_flush,
  input  logic [NUM_STAGES*ID_W-1:0] stage_id,
  output logic                       rec_valid,
  input  logic                       rec_ready,
  output logic [REC_W-1:0]           rec_data,
  output logic [OCC_W-1:0]           occupancy,
  output logic [15:0]                drop_cnt,
  output logic                       overflow,
  output logic [1:0]                 state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUN = 2'd2} state_e;

  state_e                    state_q, state_d;
  logic [TS_W-1:0]           ts_q, ts_d;
  logic [AW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]          occ_q, occ_d;
  logic [15:0]               drop_cnt_q, drop_cnt_d;
  logic                      overflow_q, overflow_d;
  logic                      gap_q, gap_d;
  logic [3*NUM_STAGES-1:0]   last_q, last_d;
  logic [REC_W-1:0]          mem_q [DEPTH];

  logic [3*NUM_STAGES-1:0]   masks;
  logic [REC_W-1:0]          rec_d;
  logic                      due, pop, push, drop, full;

  assign masks = {stage_valid, stage_stall, stage_flush};
  assign rec_d = {gap_q, ts_q, masks, stage_id};
  assign full  = (occ_q == OCC_W'(DEPTH));
  assign pop   = (occ_q != '0) && rec_ready;
  // Only the registered state decides recording, so the trig-sampling cycle in ARMED is never due.
  assign due   = (state_q == RUN) &&
                 ((ON_CHANGE == 0) || (|(stage_valid & ~stage_stall)) || (masks != last_q));
  assign push  = due && (!full || pop);
  assign drop  = due && !push;

  always_comb begin
    state_d = state_q;
    if (!trace_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = use_trig ? ARMED : RUN;
        ARMED:   if (trig) state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ts_d       = ts_q + TS_W'(1);
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    occ_d      = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    overflow_d = overflow_q | drop;
    gap_d      = gap_q;
    if (push)      gap_d = 1'b0;
    else if (drop) gap_d = 1'b1;
    // Reference masks restart from zero on each entry to RUN so the first RUN cycle can record.
    last_d     = last_q;
    if ((state_q != RUN) && (state_d == RUN)) last_d = '0;
    else if (due)                             last_d = masks;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
      gap_q      <= 1'b0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
      gap_q      <= gap_d;
      last_q     <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rec_d;
  end

  assign rec_valid = (occ_q != '0);
  assign rec_data  = rec_valid ? mem_q[rd_ptr_q] : '0;
  assign occupancy = occ_q;
  assign drop_cnt  = drop_cnt_q;
  assign overflow  = overflow_q;
  assign state_o   = state_q;

endmodule
